seq010_tx: RTL

- Serial token transmitter: the driving end of the "010" sequence-detector link.
- Takes a request for N user tokens on a valid/ready handshake and serializes each token onto the single-bit line x as the frame 0,1,0, followed by idle '1' gap bits.
- The gap returns the downstream 010 detector from its Store state to Idle, so every frame produces exactly one detection and one users_count increment.
- Keeps a cumulative sent-token count for scoreboarding against the detector.

---
 rtl/seq010_tx_if.sv | 11 +
 rtl/seq010_tx.sv | 101 ++++++++++
 2 files changed

// File: rtl/seq010_tx_if.sv
// rtl/seq010_tx_if.sv - request handshake between a token requester and seq010_tx
interface seq010_tx_if #(
  parameter int COUNT_W = 10
);
  logic               req_valid;
  logic [COUNT_W-1:0] req_count;
  logic               req_ready;

  modport master (output req_valid, output req_count, input req_ready);
  modport slave  (input req_valid, input req_count, output req_ready);
endinterface

// File: rtl/seq010_tx.sv
// rtl/seq010_tx.sv - serializes N tokens as 0,1,0 frames plus idle-1 gap bits on x
module seq010_tx #(
  parameter int COUNT_W  = 10,
  parameter int GAP_BITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  seq010_tx_if.slave         req,
  input  logic               clr_count,
  output logic               x,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sent_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    GAP  = 3'd4
  } state_t;

  // Gap counter runs 0..GAP_BITS-1; 4 bits covers the 1..15 range.
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [COUNT_W-1:0] sent_q, sent_d;
  logic [3:0]         gap_q, gap_d;
  logic               x_q, x_d;
  logic               done_q, done_d;

  // State, line and counters; reset abandons any partial frame uncounted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      sent_q      <= '0;
      gap_q       <= '0;
      x_q         <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      gap_q       <= gap_d;
      x_q         <= x_d;
      done_q      <= done_d;
    end
  end

  // Next state; x is derived from the next state so it moves with the state register.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          remaining_d = req.req_count;
          if (req.req_count != '0) state_d = B0;
          else                     done_d  = 1'b1;
        end
      end
      B0: state_d = B1;
      B1: state_d = B2;
      B2: begin
        // Counting here lines up with the detector registering the trailing 0.
        state_d     = GAP;
        gap_d       = '0;
        sent_d      = sent_q + COUNT_W'(1);
        remaining_d = remaining_q - COUNT_W'(1);
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (remaining_q != '0) begin
            state_d = B0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_count) sent_d = '0;
    x_d = !((state_d == B0) || (state_d == B2));
  end

  assign req.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign x             = x_q;
  assign done          = done_q;
  assign sent_count    = sent_q;

endmodule
